regfile_mp: RTL and testbench

- Parametrised multi-port integer register file; the next generation of the core's single-write/dual-read register file.
- Sits between decode (read ports) and writeback (write ports) and supports dual-issue writeback.
- Adds configurable read/write port counts, optional same-cycle write-to-read bypass, deterministic write-port priority, and a post-reset hardware clear sequencer that zeroes every entry.

---
 rtl/regfile_mp.sv | 104 ++++++++++
 tb/tb_regfile_mp.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file with
// same-cycle write bypass, write-port priority and a post-reset clear pass.
module regfile_mp #(
  parameter int XLEN     = 64,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_WR-1:0]        wr_en_in,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr_in,
  input  logic [NUM_WR*XLEN-1:0]   wr_data_in,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_in,
  output logic [NUM_RD*XLEN-1:0]   rd_data_out,
  output logic                     init_done_out
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] clr_ptr;
  logic [ADDR_W-1:0] clr_ptr_nxt;
  logic              done_nxt;
  logic [XLEN-1:0]   regs [DEPTH];
  logic [ADDR_W-1:0] ra;
  logic [XLEN-1:0]   rv;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= CLEAR;
      clr_ptr       <= '0;
      init_done_out <= 1'b0;
    end else begin
      state         <= state_nxt;
      clr_ptr       <= clr_ptr_nxt;
      init_done_out <= done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    done_nxt    = init_done_out;
    unique case (state)
      CLEAR: begin
        clr_ptr_nxt = clr_ptr + ADDR_W'(1);
        if (&clr_ptr) begin
          state_nxt = RUN;
          done_nxt  = 1'b1;
        end
      end
      RUN: begin
        done_nxt = 1'b1;
      end
      default: begin
        state_nxt = CLEAR;
      end
    endcase
  end

  // later ports are assigned last, so they win address conflicts
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == CLEAR) begin
        regs[clr_ptr] <= '0;
      end else begin
        for (int k = 0; k < NUM_WR; k++) begin
          if (wr_en_in[k] &&
              !(ZERO_REG != 0 &&
                wr_addr_in[k*ADDR_W +: ADDR_W] == '0))
            regs[wr_addr_in[k*ADDR_W +: ADDR_W]] <=
              wr_data_in[k*XLEN +: XLEN];
        end
      end
    end
  end

  always_comb begin
    rd_data_out = '0;
    ra          = '0;
    rv          = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      ra = rd_addr_in[r*ADDR_W +: ADDR_W];
      rv = regs[ra];
      if (BYPASS != 0) begin
        for (int k = 0; k < NUM_WR; k++) begin
          if (wr_en_in[k] &&
              wr_addr_in[k*ADDR_W +: ADDR_W] == ra)
            rv = wr_data_in[k*XLEN +: XLEN];
        end
      end
      if (ZERO_REG != 0 && ra == '0) rv = '0;
      if (state != RUN) rv = '0;
      rd_data_out[r*XLEN +: XLEN] = rv;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed + random checks of regfile_mp against a
// behavioural array model, for a bypass/zero-reg and a plain instance.
module tb_regfile_mp;

  logic             clk;
  logic             rst_n;
  logic [1:0]       we;
  logic [1:0][4:0]  wa;
  logic [1:0][63:0] wd;
  logic [1:0][4:0]  ra;
  logic [1:0][63:0] rd_a;
  logic [1:0][63:0] rd_b;
  logic             done_a;
  logic             done_b;

  int compared   = 0;
  int mismatched = 0;

  logic [63:0] ma [32];
  logic [63:0] mb [32];
  bit          m_clear = 1'b1;
  bit          m_done  = 1'b0;
  int          m_ptr   = 0;

  regfile_mp dut_a (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_en_in      (we),
    .wr_addr_in    (wa),
    .wr_data_in    (wd),
    .rd_addr_in    (ra),
    .rd_data_out   (rd_a),
    .init_done_out (done_a)
  );

  regfile_mp #(.BYPASS(0), .ZERO_REG(0)) dut_b (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_en_in      (we),
    .wr_addr_in    (wa),
    .wr_data_in    (wd),
    .rd_addr_in    (ra),
    .rd_data_out   (rd_b),
    .init_done_out (done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mread(bit inst, logic [4:0] a);
    if (m_clear) return 64'd0;
    if (inst == 1'b0) begin
      if (a == 5'd0) return 64'd0;
      for (int k = 1; k >= 0; k--)
        if (we[k] && wa[k] == a) return wd[k];
      return ma[a];
    end
    return mb[a];
  endfunction

  task automatic cmp(string tag, logic [63:0] obs, logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    we = 2'b00;
    wa = '0;
    wd = '0;
  endtask

  task automatic half(string tag);
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      cmp($sformatf("%s rdA%0d", tag, p), rd_a[p], mread(1'b0, ra[p]));
      cmp($sformatf("%s rdB%0d", tag, p), rd_b[p], mread(1'b1, ra[p]));
    end
    cmp({tag, " doneA"}, 64'(done_a), 64'(m_done));
    cmp({tag, " doneB"}, 64'(done_b), 64'(m_done));
  endtask

  task automatic edge_();
    @(posedge clk);
    if (!rst_n) begin
      m_clear = 1'b1;
      m_done  = 1'b0;
      m_ptr   = 0;
    end else if (m_clear) begin
      ma[m_ptr] = 64'd0;
      mb[m_ptr] = 64'd0;
      m_ptr++;
      if (m_ptr == 32) begin
        m_clear = 1'b0;
        m_done  = 1'b1;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (we[k]) begin
          mb[wa[k]] = wd[k];
          if (wa[k] != 5'd0) ma[wa[k]] = wd[k];
        end
      end
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    ra = '0;
    edge_();
    repeat (2) begin
      half("rst");
      edge_();
    end

    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      idle();
      ra = {5'd5, 5'd5};
      if (i == 16) begin
        we    = 2'b01;
        wa[0] = 5'd5;
        wd[0] = 64'hAA;
      end
      half("clr");
      cmp("clr_done", 64'(done_a), 64'd0);
      edge_();
    end
    idle();
    half("run0");
    cmp("done33", 64'(done_a), 64'd1);
    cmp("clr_a5", rd_a[0], 64'd0);
    cmp("clr_b5", rd_b[1], 64'd0);
    edge_();

    we = 2'b01; wa[0] = 5'd3; wd[0] = 64'h1234; ra = {5'd0, 5'd3};
    half("wr3");
    cmp("nobyp_same", rd_b[0], 64'd0);
    cmp("byp_same3", rd_a[0], 64'h1234);
    edge_();
    idle();
    half("rd3");
    cmp("nobyp_next", rd_b[0], 64'h1234);
    edge_();

    we = 2'b10; wa[1] = 5'd7; wd[1] = 64'hDEAD_BEEF; ra = {5'd7, 5'd7};
    half("byp7");
    cmp("byp7_p1", rd_a[1], 64'hDEAD_BEEF);
    edge_();

    we = 2'b11; wa = {5'd9, 5'd9}; wd = {64'h22, 64'h11}; ra = {5'd9, 5'd9};
    half("conf9");
    cmp("conf_byp", rd_a[0], 64'h22);
    edge_();
    idle();
    half("conf9n");
    cmp("conf_a", rd_a[0], 64'h22);
    cmp("conf_b", rd_b[1], 64'h22);
    edge_();

    we = 2'b11; wa = '0; wd = {64'hFFFF, 64'hFFFF}; ra = '0;
    half("zero");
    cmp("zero_same", rd_a[0], 64'd0);
    edge_();
    idle();
    half("zeron");
    cmp("zero_next", rd_a[1], 64'd0);
    cmp("zero_plain", rd_b[0], 64'hFFFF);
    edge_();

    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      for (int k = 0; k < 2; k++) begin
        we[k] = 1'($urandom_range(0, 1));
        wa[k] = ($urandom_range(0, 1) != 0) ?
                5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
        wd[k] = {$urandom, $urandom};
        ra[k] = ($urandom_range(0, 1) != 0) ?
                5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      end
      half("rand");
      edge_();
    end

    rst_n = 1'b1;
    idle();
    repeat (40) begin
      half("idle");
      edge_();
    end
    we = 2'b11; wa = {5'd2, 5'd1}; wd = {64'h202, 64'h101};
    half("fill12");
    edge_();
    wa = {5'd4, 5'd3}; wd = {64'h404, 64'h303};
    half("fill34");
    edge_();
    idle();
    ra = {5'd4, 5'd1};
    half("filled");
    cmp("fill4", rd_a[1], 64'h404);
    rst_n = 1'b0;
    edge_();
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      half("reclr");
      cmp("reclr_done", 64'(done_a), 64'd0);
      edge_();
    end
    ra = {5'd2, 5'd1};
    half("after12");
    cmp("after1", rd_a[0], 64'd0);
    cmp("after2", rd_b[1], 64'd0);
    cmp("after_done", 64'(done_b), 64'd1);
    edge_();
    ra = {5'd4, 5'd3};
    half("after34");
    cmp("after3", rd_b[0], 64'd0);
    cmp("after4", rd_a[1], 64'd0);
    edge_();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
